// File: rtl/register_file_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Holds the port structs, the sweep FSM states and a range-check helper.
package register_file_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;

    typedef struct packed {
        logic                     enable;
        logic [RF_ADDR_WIDTH-1:0] address;
        logic [RF_DATA_WIDTH-1:0] data;
    } rf_write_t;

    typedef struct packed {
        logic                     enable;
        logic [RF_ADDR_WIDTH-1:0] address;
    } rf_claim_t;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } rf_state_e;

    // Non-power-of-two depths leave a tail of addresses with no backing register.
    function automatic logic rf_in_range(input int unsigned address, input int unsigned count);
        return address < count;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit vector: set by claims at issue, cleared by writeback or flush.
// Incoming claim/write valids are already qualified by the top level.
module rf_scoreboard
    import register_file_pkg::*;
#(
    parameter int unsigned RegisterCount  = 32,
    parameter int unsigned AddressWidth   = 5,
    parameter int unsigned ReadPortCount  = 2,
    parameter int unsigned WritePortCount = 1,
    parameter int unsigned ClaimPortCount = 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        ready,
    input  logic                                        flush,
    input  logic [ClaimPortCount-1:0]                   claim_valid,
    input  logic [ClaimPortCount-1:0][AddressWidth-1:0] claim_address,
    input  logic [WritePortCount-1:0]                   write_valid,
    input  logic [WritePortCount-1:0][AddressWidth-1:0] write_address,
    input  logic [ReadPortCount-1:0][AddressWidth-1:0]  read_address,
    output logic [ReadPortCount-1:0]                    read_pending
);

    logic [RegisterCount-1:0] pending;
    logic [RegisterCount-1:0] pending_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pending_next = pending;
        if (ready && flush) begin
            pending_next = '0;
        end
        for (int w = 0; w < int'(WritePortCount); w++) begin
            if (write_valid[w]) begin
                pending_next[write_address[w]] = 1'b0;
            end
        end
        // Claims are applied last so a same-cycle claim beats both writeback and flush.
        for (int c = 0; c < int'(ClaimPortCount); c++) begin
            if (claim_valid[c]) begin
                pending_next[claim_address[c]] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    always_comb begin
        read_pending = '0;
        for (int r = 0; r < int'(ReadPortCount); r++) begin
            if (ready && rf_in_range(32'(read_address[r]), RegisterCount)) begin
                read_pending[r] = pending[read_address[r]];
            end
        end
    end

endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-port integer register file with write-to-read bypass, pending scoreboard
// and a post-reset zeroing sweep that gates all traffic until complete.
module scoreboard_register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DataWidth      = RF_DATA_WIDTH,
    parameter int unsigned RegisterCount  = 32,
    parameter int unsigned ReadPortCount  = 2,
    parameter int unsigned WritePortCount = 1,
    parameter int unsigned ClaimPortCount = 1,
    parameter bit          ZeroRegister   = 1'b1,
    localparam int unsigned AddressWidth  = $clog2(RegisterCount)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    output logic                                     ready_o,
    input  logic [ReadPortCount-1:0][AddressWidth-1:0] read_address_i,
    output logic [ReadPortCount-1:0][DataWidth-1:0]  read_data_o,
    output logic [ReadPortCount-1:0]                 read_pending_o,
    input  rf_claim_t [ClaimPortCount-1:0]           claim_i,
    input  rf_write_t [WritePortCount-1:0]           write_i,
    input  logic                                     flush_i
);

    rf_state_e               state;
    rf_state_e               state_next;
    logic [AddressWidth-1:0] sweep_count;
    logic [DataWidth-1:0]    registers [RegisterCount];

    logic [WritePortCount-1:0]                   write_valid;
    logic [WritePortCount-1:0][AddressWidth-1:0] write_address;
    logic [ClaimPortCount-1:0]                   claim_valid;
    logic [ClaimPortCount-1:0][AddressWidth-1:0] claim_address;
    logic                                        write_conflict;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_CLEAR;
            sweep_count <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                sweep_count <= sweep_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        ready_o    = (state == ST_READY);
        if (state == ST_CLEAR && 32'(sweep_count) == RegisterCount - 1) begin
            state_next = ST_READY;
        end
    end

    // Register 0 and out-of-range targets are filtered here so nothing downstream sees them.
    always_comb begin
        write_valid   = '0;
        write_address = '0;
        claim_valid   = '0;
        claim_address = '0;
        for (int w = 0; w < int'(WritePortCount); w++) begin
            write_address[w] = AddressWidth'(write_i[w].address);
            write_valid[w]   = write_i[w].enable && ready_o
                             && rf_in_range(32'(write_address[w]), RegisterCount)
                             && !(ZeroRegister && write_address[w] == '0);
        end
        for (int c = 0; c < int'(ClaimPortCount); c++) begin
            claim_address[c] = AddressWidth'(claim_i[c].address);
            claim_valid[c]   = claim_i[c].enable && ready_o
                             && rf_in_range(32'(claim_address[c]), RegisterCount)
                             && !(ZeroRegister && claim_address[c] == '0);
        end
    end

    // NOTE: the array has no reset; the sweep clears it, which keeps it mappable to RAM.
    always_ff @(posedge clk_i) begin
        if (state == ST_CLEAR) begin
            if (rf_in_range(32'(sweep_count), RegisterCount)) begin
                registers[sweep_count] <= '0;
            end
        end else begin
            // Later loop iterations override earlier ones, so the highest port index wins.
            for (int w = 0; w < int'(WritePortCount); w++) begin
                if (write_valid[w]) begin
                    registers[write_address[w]] <= DataWidth'(write_i[w].data);
                end
            end
        end
    end

    always_comb begin
        read_data_o = '0;
        for (int r = 0; r < int'(ReadPortCount); r++) begin
            if (ready_o && rf_in_range(32'(read_address_i[r]), RegisterCount)
                && !(ZeroRegister && read_address_i[r] == '0)) begin
                read_data_o[r] = registers[read_address_i[r]];
                for (int w = 0; w < int'(WritePortCount); w++) begin
                    if (write_valid[w] && write_address[w] == read_address_i[r]) begin
                        read_data_o[r] = DataWidth'(write_i[w].data);
                    end
                end
            end
        end
    end

    always_comb begin
        write_conflict = 1'b0;
        for (int i = 0; i < int'(WritePortCount); i++) begin
            for (int j = i + 1; j < int'(WritePortCount); j++) begin
                if (write_valid[i] && write_valid[j] && write_address[i] == write_address[j]) begin
                    write_conflict = 1'b1;
                end
            end
        end
    end

    rf_scoreboard #(
        .RegisterCount (RegisterCount),
        .AddressWidth  (AddressWidth),
        .ReadPortCount (ReadPortCount),
        .WritePortCount(WritePortCount),
        .ClaimPortCount(ClaimPortCount)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ready        (ready_o),
        .flush        (flush_i),
        .claim_valid  (claim_valid),
        .claim_address(claim_address),
        .write_valid  (write_valid),
        .write_address(write_address),
        .read_address (read_address_i),
        .read_pending (read_pending_o)
    );

    conflict_warn: assert property (@(posedge clk_i) disable iff (!rst_ni) !write_conflict)
        else $warning("register file: several writes to one register in a cycle, highest port kept");

    zero_reg_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ZeroRegister && ready_o) |-> registers[0] == '0);

    read_data_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ready_o |-> !$isunknown(read_data_o));

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench: stimulus pushes expected outputs into a queue, a negedge monitor
// pops and compares them against the DUT.
module tb_scoreboard_register_file;
    import register_file_pkg::*;

    logic                 clk_i;
    logic                 rst_ni;
    logic                 ready_o;
    logic [1:0][4:0]      read_address_i;
    logic [1:0][31:0]     read_data_o;
    logic [1:0]           read_pending_o;
    rf_claim_t [0:0]      claim_i;
    rf_write_t [1:0]      write_i;
    logic                 flush_i;

    scoreboard_register_file #(
        .DataWidth     (32),
        .RegisterCount (32),
        .ReadPortCount (2),
        .WritePortCount(2),
        .ClaimPortCount(1),
        .ZeroRegister  (1'b1)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ready_o       (ready_o),
        .read_address_i(read_address_i),
        .read_data_o   (read_data_o),
        .read_pending_o(read_pending_o),
        .claim_i       (claim_i),
        .write_i       (write_i),
        .flush_i       (flush_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef enum int {K_READY, K_DATA0, K_DATA1, K_PEND0, K_PEND1} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    always @(negedge clk_i) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            case (e.kind)
                K_READY: check(e.name, 32'(ready_o), e.value);
                K_DATA0: check(e.name, read_data_o[0], e.value);
                K_DATA1: check(e.name, read_data_o[1], e.value);
                K_PEND0: check(e.name, 32'(read_pending_o[0]), e.value);
                K_PEND1: check(e.name, 32'(read_pending_o[1]), e.value);
                default: check(e.name, 32'hFFFF_FFFF, e.value);
            endcase
        end
    end

    task automatic expect_val(input string name, input kind_e kind, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        write_i = '0;
        claim_i = '0;
        flush_i = 1'b0;
    endtask

    task automatic drive_write(input int port, input logic [4:0] address, input logic [31:0] data);
        write_i[port].enable  = 1'b1;
        write_i[port].address = address;
        write_i[port].data    = data;
    endtask

    task automatic drive_claim(input logic [4:0] address);
        claim_i[0].enable  = 1'b1;
        claim_i[0].address = address;
    endtask

    // Called right after rst_ni deasserts: ready must stay low for exactly 32 edges.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < 32; i++) begin
            expect_val($sformatf("%s ready low c%0d", tag, i), K_READY, 0);
            if (i == 0 || i == 31) begin
                expect_val($sformatf("%s data during sweep c%0d", tag, i), K_DATA0, 0);
                expect_val($sformatf("%s pend during sweep c%0d", tag, i), K_PEND0, 0);
            end
            step();
        end
        expect_val({tag, " ready high"}, K_READY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni         = 1'b0;
        read_address_i = '0;
        idle();
        repeat (3) step();
        expect_val("ready in reset", K_READY, 0);
        step();

        rst_ni            = 1'b1;
        read_address_i[0] = 5'd5;
        sweep_check("sweep1");

        for (int i = 0; i < 32; i++) begin
            read_address_i[0] = 5'(i);
            read_address_i[1] = 5'(31 - i);
            expect_val($sformatf("swept x%0d", i), K_DATA0, 0);
            expect_val($sformatf("swept x%0d", 31 - i), K_DATA1, 0);
            step();
        end

        // Bypass
        drive_write(0, 5'd5, 32'hDEAD_BEEF);
        read_address_i[0] = 5'd5;
        read_address_i[1] = 5'd6;
        expect_val("bypass x5", K_DATA0, 32'hDEAD_BEEF);
        expect_val("bypass x6", K_DATA1, 32'h0);
        step();
        idle();
        expect_val("stored x5", K_DATA0, 32'hDEAD_BEEF);
        step();

        // Zero register
        drive_write(0, 5'd0, 32'h0000_1234);
        drive_claim(5'd0);
        read_address_i[0] = 5'd0;
        expect_val("x0 bypass blocked", K_DATA0, 0);
        expect_val("x0 pend same cycle", K_PEND0, 0);
        step();
        idle();
        expect_val("x0 stays zero", K_DATA0, 0);
        expect_val("x0 never pending", K_PEND0, 0);
        step();

        // Write conflict, port 1 wins
        drive_write(0, 5'd7, 32'h1);
        drive_write(1, 5'd7, 32'h2);
        read_address_i[0] = 5'd7;
        expect_val("conflict bypass x7", K_DATA0, 32'h2);
        step();
        idle();
        expect_val("conflict stored x7", K_DATA0, 32'h2);
        step();

        // Scoreboard
        drive_claim(5'd3);
        read_address_i[0] = 5'd3;
        expect_val("x3 pend before claim edge", K_PEND0, 0);
        step();
        idle();
        expect_val("x3 pend after claim", K_PEND0, 1);
        step();
        drive_write(0, 5'd3, 32'h55);
        expect_val("x3 pend during write", K_PEND0, 1);
        expect_val("x3 data bypassed", K_DATA0, 32'h55);
        step();
        idle();
        expect_val("x3 pend cleared", K_PEND0, 0);
        expect_val("x3 data stored", K_DATA0, 32'h55);
        step();
        drive_claim(5'd3);
        drive_write(0, 5'd3, 32'h55);
        step();
        idle();
        expect_val("claim beats write pend", K_PEND0, 1);
        expect_val("claim+write data", K_DATA0, 32'h55);
        drive_claim(5'd4);
        read_address_i[1] = 5'd4;
        step();
        idle();
        expect_val("x3 pend before flush", K_PEND0, 1);
        expect_val("x4 pend before flush", K_PEND1, 1);
        flush_i = 1'b1;
        step();
        idle();
        expect_val("x3 pend after flush", K_PEND0, 0);
        expect_val("x4 pend after flush", K_PEND1, 0);
        flush_i = 1'b1;
        drive_claim(5'd4);
        step();
        idle();
        expect_val("flush+claim x4 pend", K_PEND1, 1);
        expect_val("flush+claim x3 pend", K_PEND0, 0);
        step();

        // Mid-sweep reset with a write attempted throughout
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_val($sformatf("sweep2 ready low c%0d", i), K_READY, 0);
            step();
        end
        rst_ni = 1'b0;
        drive_write(0, 5'd9, 32'h0000_ABCD);
        read_address_i[0] = 5'd9;
        read_address_i[1] = 5'd4;
        expect_val("mid-sweep reset ready", K_READY, 0);
        step();
        rst_ni = 1'b1;
        sweep_check("sweep3");
        idle();
        expect_val("x9 write ignored", K_DATA0, 0);
        expect_val("x4 pend cleared by reset", K_PEND1, 0);
        step();
        read_address_i[0] = 5'd5;
        read_address_i[1] = 5'd7;
        expect_val("x5 re-swept", K_DATA0, 0);
        expect_val("x7 re-swept", K_DATA1, 0);
        step();

        step();
        step();
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
